// File: rtl/mmcm_drp_sequencer.sv
// mmcm_drp_sequencer: applies host-loaded DRP read-modify-write entries to an MMCME2_ADV
// while holding it in reset. Build option MMCM_LOCK_TIMEOUT_EN bounds the wait for LOCKED.
module mmcm_drp_sequencer #(
    parameter int DEPTH        = 8,
    parameter int IDX_W        = $clog2(DEPTH),
    parameter int RST_HOLD     = 4,
    parameter int DRDY_TIMEOUT = 64
) (
    input  logic             DCLK,
    input  logic             RST_N,
    input  logic             CFG_WE,
    input  logic [IDX_W-1:0] CFG_IDX,
    input  logic [6:0]       CFG_DADDR,
    input  logic [15:0]      CFG_MASK,
    input  logic [15:0]      CFG_DATA,
    input  logic [IDX_W:0]   CFG_CNT,
    input  logic             START,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic [6:0]       DADDR,
    output logic             DEN,
    output logic             DWE,
    output logic [15:0]      DI,
    input  logic [15:0]      DO,
    input  logic             DRDY,
    output logic             MMCM_RST,
    input  logic             LOCKED
);

    localparam int HOLD_W = $clog2(RST_HOLD + 1);
    localparam int TMO_W  = $clog2(DRDY_TIMEOUT + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(DRDY_TIMEOUT - 1);
    localparam logic [IDX_W:0]    CNT_MAX   = (IDX_W + 1)'(DEPTH);

    typedef enum logic [3:0] {
        ST_POR       = 4'd0,
        ST_IDLE      = 4'd1,
        ST_ASSERT    = 4'd2,
        ST_RD        = 4'd3,
        ST_WAIT_RD   = 4'd4,
        ST_WR        = 4'd5,
        ST_WAIT_WR   = 4'd6,
        ST_RELEASE   = 4'd7,
        ST_WAIT_LOCK = 4'd8
    } state_t;

    state_t            state_r;
    logic [38:0]       tbl_r [DEPTH];
    logic [IDX_W-1:0]  idx_r;
    logic [IDX_W:0]    cnt_r;
    logic [HOLD_W-1:0] hold_r;
    logic [TMO_W-1:0]  tmo_r;
    logic              lock_meta_r;
    logic              lock_s;
    logic              busy_r;
    logic              done_r;
    logic              err_r;
    logic              den_r;
    logic              dwe_r;
    logic              mmcm_rst_r;
    logic [6:0]        daddr_r;
    logic [15:0]       di_r;
    logic [IDX_W-1:0]  idx_nxt_s;
    logic              last_s;
`ifdef MMCM_LOCK_TIMEOUT_EN
    logic [15:0]       lock_cnt_r;
`endif

    function automatic logic [15:0] rmw_merge(input logic [15:0] rd,
                                              input logic [15:0] keep,
                                              input logic [15:0] set);
        return (rd & keep) | set;
    endfunction

    assign idx_nxt_s = idx_r + IDX_W'(1);
    assign last_s    = ({1'b0, idx_r} == (cnt_r - (IDX_W + 1)'(1)));

    assign BUSY     = busy_r;
    assign DONE     = done_r;
    assign ERR      = err_r;
    assign DADDR    = daddr_r;
    assign DEN      = den_r;
    assign DWE      = dwe_r;
    assign DI       = di_r;
    assign MMCM_RST = mmcm_rst_r;

    // Two-flop synchronizer bringing LOCKED into the DCLK domain.
    always_ff @(posedge DCLK or negedge RST_N) begin
        if (!RST_N) begin
            lock_meta_r <= 1'b0;
            lock_s      <= 1'b0;
        end else begin
            lock_meta_r <= LOCKED;
            lock_s      <= lock_meta_r;
        end
    end

    // Entry table; deliberately not reset, the host loads entries before use.
    always_ff @(posedge DCLK) begin
        if (CFG_WE && !busy_r) begin
            tbl_r[CFG_IDX] <= {CFG_DADDR, CFG_MASK, CFG_DATA};
        end
    end

    // Sequencer FSM; DEN/DWE/DONE default low so each is a single-cycle pulse.
    always_ff @(posedge DCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r    <= ST_POR;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            den_r      <= 1'b0;
            dwe_r      <= 1'b0;
            daddr_r    <= 7'd0;
            di_r       <= 16'd0;
            mmcm_rst_r <= 1'b1;
            idx_r      <= {IDX_W{1'b0}};
            cnt_r      <= {(IDX_W + 1){1'b0}};
            hold_r     <= {HOLD_W{1'b0}};
            tmo_r      <= {TMO_W{1'b0}};
`ifdef MMCM_LOCK_TIMEOUT_EN
            lock_cnt_r <= 16'd0;
`endif
        end else begin
            done_r <= 1'b0;
            den_r  <= 1'b0;
            dwe_r  <= 1'b0;
            case (state_r)
                ST_POR: begin
                    mmcm_rst_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (START) begin
                        busy_r     <= 1'b1;
                        err_r      <= 1'b0;
                        mmcm_rst_r <= 1'b1;
                        idx_r      <= {IDX_W{1'b0}};
                        hold_r     <= {HOLD_W{1'b0}};
                        cnt_r      <= (CFG_CNT > CNT_MAX) ? CNT_MAX : CFG_CNT;
                        state_r    <= ST_ASSERT;
                    end
                end
                ST_ASSERT: begin
                    if (hold_r == HOLD_LAST) begin
                        hold_r <= {HOLD_W{1'b0}};
                        if (cnt_r == {(IDX_W + 1){1'b0}}) begin
                            state_r <= ST_RELEASE;
                        end else begin
                            daddr_r <= tbl_r[idx_r][38:32];
                            den_r   <= 1'b1;
                            state_r <= ST_RD;
                        end
                    end else begin
                        hold_r <= hold_r + HOLD_W'(1);
                    end
                end
                ST_RD: begin
                    tmo_r   <= {TMO_W{1'b0}};
                    state_r <= ST_WAIT_RD;
                end
                ST_WAIT_RD: begin
                    if (DRDY) begin
                        di_r    <= rmw_merge(DO, tbl_r[idx_r][31:16], tbl_r[idx_r][15:0]);
                        den_r   <= 1'b1;
                        dwe_r   <= 1'b1;
                        state_r <= ST_WR;
                    end else if (tmo_r == TMO_LAST) begin
                        err_r   <= 1'b1;
                        state_r <= ST_RELEASE;
                    end else begin
                        tmo_r <= tmo_r + TMO_W'(1);
                    end
                end
                ST_WR: begin
                    tmo_r   <= {TMO_W{1'b0}};
                    state_r <= ST_WAIT_WR;
                end
                ST_WAIT_WR: begin
                    if (DRDY) begin
                        if (last_s) begin
                            state_r <= ST_RELEASE;
                        end else begin
                            idx_r   <= idx_nxt_s;
                            daddr_r <= tbl_r[idx_nxt_s][38:32];
                            den_r   <= 1'b1;
                            state_r <= ST_RD;
                        end
                    end else if (tmo_r == TMO_LAST) begin
                        err_r   <= 1'b1;
                        state_r <= ST_RELEASE;
                    end else begin
                        tmo_r <= tmo_r + TMO_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (hold_r == HOLD_LAST) begin
                        hold_r     <= {HOLD_W{1'b0}};
                        mmcm_rst_r <= 1'b0;
`ifdef MMCM_LOCK_TIMEOUT_EN
                        lock_cnt_r <= 16'd0;
`endif
                        state_r    <= ST_WAIT_LOCK;
                    end else begin
                        hold_r <= hold_r + HOLD_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    // An aborted sequence still waits for lock but never reports DONE.
                    if (lock_s) begin
                        done_r  <= ~err_r;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
`ifdef MMCM_LOCK_TIMEOUT_EN
                    else if (lock_cnt_r == 16'hFFFE) begin
                        err_r   <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        lock_cnt_r <= lock_cnt_r + 16'd1;
                    end
`endif
                end
                default: begin
                    busy_r     <= 1'b0;
                    mmcm_rst_r <= 1'b1;
                    state_r    <= ST_POR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmcm_drp_sequencer.sv
// tb_mmcm_drp_sequencer: DRP slave, LOCKED model and a table-level reference model
// for mmcm_drp_sequencer, with directed and randomized sequences.
`timescale 1ns/1ps
module tb_mmcm_drp_sequencer;
    localparam int DEPTH        = 8;
    localparam int IDX_W        = 3;
    localparam int RST_HOLD     = 4;
    localparam int DRDY_TIMEOUT = 64;
    localparam int LOCK_DLY     = 10;

    logic             dclk      = 1'b0;
    logic             rst_n     = 1'b0;
    logic             cfg_we    = 1'b0;
    logic [IDX_W-1:0] cfg_idx   = '0;
    logic [6:0]       cfg_daddr = 7'd0;
    logic [15:0]      cfg_mask  = 16'd0;
    logic [15:0]      cfg_data  = 16'd0;
    logic [IDX_W:0]   cfg_cnt   = '0;
    logic             start     = 1'b0;
    logic             busy, done, err, den, dwe, mmcm_rst;
    logic [6:0]       daddr;
    logic [15:0]      di;
    logic [15:0]      do_v      = 16'd0;
    logic             drdy      = 1'b0;
    logic             locked    = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic [38:0] tbl     [DEPTH];
    logic [15:0] drp_mem [128];
    logic [15:0] ref_mem [128];
    logic [23:0] obs_q [$];
    logic [23:0] exp_q [$];
    int          lat     = 1;
    bit          hang_en = 1'b0;
    int          hang_rd = 0;
    bit          hung    = 1'b0;
    int          pend    = 0;
    logic [15:0] pend_data;
    int          rd_seen = 0;
    int          lk_cnt  = 0;

    mmcm_drp_sequencer #(.DEPTH(DEPTH), .IDX_W(IDX_W), .RST_HOLD(RST_HOLD),
                         .DRDY_TIMEOUT(DRDY_TIMEOUT)) dut (
        .DCLK(dclk), .RST_N(rst_n), .CFG_WE(cfg_we), .CFG_IDX(cfg_idx),
        .CFG_DADDR(cfg_daddr), .CFG_MASK(cfg_mask), .CFG_DATA(cfg_data),
        .CFG_CNT(cfg_cnt), .START(start), .BUSY(busy), .DONE(done), .ERR(err),
        .DADDR(daddr), .DEN(den), .DWE(dwe), .DI(di), .DO(do_v), .DRDY(drdy),
        .MMCM_RST(mmcm_rst), .LOCKED(locked)
    );

    always #5 dclk = ~dclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, expv);
        end
    endtask

    // DRP slave: logs every access, answers after lat cycles, can hang a chosen read
    // and injects stray DRDY pulses whenever nothing is outstanding.
    initial begin
        forever begin
            @(negedge dclk);
            drdy = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    drdy = 1'b1;
                    do_v = pend_data;
                end
            end
            if (den === 1'b1) begin
                chk("den_single", {31'd0, (pend != 0) || hung}, 32'd0);
                obs_q.push_back({dwe, daddr, (dwe === 1'b1) ? di : 16'h0000});
                if (dwe === 1'b1) begin
                    drp_mem[daddr] = di;
                    pend = lat;
                    pend_data = 16'h0000;
                end else begin
                    if (hang_en && rd_seen == hang_rd) hung = 1'b1;
                    else begin
                        pend = lat;
                        pend_data = drp_mem[daddr];
                    end
                    rd_seen++;
                end
            end else if (pend == 0 && !hung && !drdy && $urandom_range(0, 7) == 0) begin
                drdy = 1'b1;
                do_v = 16'($urandom);
            end
        end
    end

    // LOCKED model: low while MMCM_RST is high, rises LOCK_DLY cycles after release.
    initial begin
        forever begin
            @(negedge dclk);
            if (mmcm_rst !== 1'b0) begin
                locked = 1'b0;
                lk_cnt = 0;
            end else if (lk_cnt < LOCK_DLY) lk_cnt++;
            else locked = 1'b1;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tbl_wr(input int i, input logic [6:0] a, input logic [15:0] m, input logic [15:0] d);
        @(negedge dclk);
        cfg_we = 1'b1; cfg_idx = i[IDX_W-1:0]; cfg_daddr = a; cfg_mask = m; cfg_data = d;
        tbl[i] = {a, m, d};
        @(negedge dclk);
        cfg_we = 1'b0;
    endtask

    task automatic run_seq(input int cnt, input bit poke_busy, input bit rst_mid);
        int ncl, rst_hi_pre, done_n, err_k, fall_k, last_den_k;
        bit exp_err, seen_den, finished;
        logic [6:0]  a;
        logic [15:0] wv;
        repeat (4) @(negedge dclk);
        obs_q.delete(); exp_q.delete();
        rd_seen = 0; hung = 1'b0; exp_err = 1'b0;
        ncl = (cnt > DEPTH) ? DEPTH : cnt;
        for (int i = 0; i < ncl; i++) begin
            a = tbl[i][38:32];
            exp_q.push_back({1'b0, a, 16'h0000});
            if (hang_en && i == hang_rd) begin
                exp_err = 1'b1;
                break;
            end
            wv = (ref_mem[a] & tbl[i][31:16]) | tbl[i][15:0];
            exp_q.push_back({1'b1, a, wv});
            ref_mem[a] = wv;
            if (rst_mid) break;
        end
        @(negedge dclk);
        cfg_cnt = cnt[IDX_W:0]; start = 1'b1;
        @(negedge dclk);
        start = 1'b0;
        chk("busy_on_start", {31'd0, busy}, 32'd1);
        chk("err_cleared", {31'd0, err}, 32'd0);
        chk("rst_asserted", {31'd0, mmcm_rst}, 32'd1);
        seen_den = 1'b0; finished = 1'b0; rst_hi_pre = 0; done_n = 0;
        err_k = -1; fall_k = -1; last_den_k = -1;
        for (int k = 0; k < 3000 && !finished; k++) begin
            if (k > 0) @(negedge dclk);
            if (den === 1'b1) begin
                seen_den = 1'b1;
                last_den_k = k;
                chk("rst_during_den", {31'd0, mmcm_rst}, 32'd1);
            end
            if (!seen_den && fall_k < 0 && mmcm_rst === 1'b1) rst_hi_pre++;
            if (err === 1'b1 && err_k < 0) err_k = k;
            if (mmcm_rst === 1'b0 && fall_k < 0) fall_k = k;
            if (done === 1'b1) begin
                done_n++;
                chk("done_with_busy_low", {31'd0, busy}, 32'd0);
            end
            if (poke_busy && k == 2) begin
                cfg_we = 1'b1; cfg_idx = '0; cfg_daddr = ~tbl[0][38:32];
                cfg_mask = 16'h1234; cfg_data = 16'h5678; cfg_cnt = '0; start = 1'b1;
            end else if (poke_busy && k == 3) begin
                cfg_we = 1'b0; start = 1'b0;
            end
            if (rst_mid && den === 1'b1 && dwe === 1'b1) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_den_low", {31'd0, den}, 32'd0);
                chk("rst_mmcm_high", {31'd0, mmcm_rst}, 32'd1);
                chk("rst_busy_low", {31'd0, busy}, 32'd0);
                finished = 1'b1;
            end
            if (busy === 1'b0) finished = 1'b1;
        end
        chk("seq_finished", {31'd0, finished}, 32'd1);
        chk("done_count", done_n, (exp_err || rst_mid) ? 32'd0 : 32'd1);
        chk("err_final", {31'd0, err}, {31'd0, exp_err});
        chk("txn_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk($sformatf("txn%0d", i), {8'd0, obs_q[i]}, {8'd0, exp_q[i]});
        if (!rst_mid) begin
            if (ncl == 0)
                chk("rst_hold_empty", {31'd0, rst_hi_pre >= 2 * RST_HOLD}, 32'd1);
            else
                chk("rst_hold_pre", {31'd0, rst_hi_pre >= RST_HOLD && rst_hi_pre <= RST_HOLD + 2}, 32'd1);
            if (exp_err) begin
                chk("drdy_timeout", {31'd0, (err_k - last_den_k) >= DRDY_TIMEOUT &&
                                            (err_k - last_den_k) <= DRDY_TIMEOUT + 3}, 32'd1);
                chk("rst_hold_after_err", {31'd0, (fall_k - err_k) >= RST_HOLD}, 32'd1);
            end else if (ncl > 0) begin
                chk("rst_hold_post", {31'd0, (fall_k - last_den_k) >= lat + 1 + RST_HOLD &&
                                             (fall_k - last_den_k) <= lat + 3 + RST_HOLD}, 32'd1);
            end
        end
    endtask

    initial begin
        int n_obs;
        int cnt_v;
        for (int a = 0; a < 128; a++) begin
            drp_mem[a] = 16'($urandom);
            ref_mem[a] = drp_mem[a];
        end
        rst_n = 1'b0;
        repeat (5) @(negedge dclk);
        chk("por_mmcm_rst", {31'd0, mmcm_rst}, 32'd1);
        chk("por_busy", {31'd0, busy}, 32'd0);
        chk("por_done", {31'd0, done}, 32'd0);
        chk("por_err", {31'd0, err}, 32'd0);
        chk("por_den_dwe", {30'd0, den, dwe}, 32'd0);
        chk("por_daddr_di", {9'd0, daddr, di}, 32'd0);
        rst_n = 1'b1;
        @(negedge dclk);
        chk("idle_release", {31'd0, mmcm_rst}, 32'd0);
        repeat (20) @(negedge dclk);
        chk("idle_no_den", obs_q.size(), 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < DEPTH; i++)
            tbl_wr(i, 7'($urandom), 16'($urandom), 16'($urandom));

        // Single entry, DO=FFFF: read-modify-write must produce 1041.
        tbl_wr(0, 7'h08, 16'h1000, 16'h0041);
        drp_mem[8] = 16'hFFFF; ref_mem[8] = 16'hFFFF;
        lat = 1;
        run_seq(1, 1'b0, 1'b0);
        chk("plan_rmw_08", {16'd0, drp_mem[8]}, 32'h1041);

        // Three entries, DRDY latency 3.
        tbl_wr(0, 7'h08, 16'($urandom), 16'($urandom));
        tbl_wr(1, 7'h09, 16'($urandom), 16'($urandom));
        tbl_wr(2, 7'h14, 16'($urandom), 16'($urandom));
        lat = 3;
        run_seq(3, 1'b0, 1'b0);

        // Second read never answered, then a clean run clears ERR.
        hang_en = 1'b1; hang_rd = 1; lat = 2;
        run_seq(3, 1'b0, 1'b0);
        hang_en = 1'b0;
        run_seq(1, 1'b0, 1'b0);

        // START and CFG_WE while busy are ignored.
        run_seq(2, 1'b1, 1'b0);
        run_seq(2, 1'b0, 1'b0);

        // Reset during the first write; the late DRDY must do nothing.
        lat = 5;
        run_seq(3, 1'b0, 1'b1);
        repeat (2) @(negedge dclk);
        rst_n = 1'b1;
        @(negedge dclk);
        chk("idle_release_again", {31'd0, mmcm_rst}, 32'd0);
        n_obs = obs_q.size();
        repeat (20) @(negedge dclk);
        chk("late_drdy_ignored", obs_q.size(), n_obs);
        chk("late_busy", {31'd0, busy}, 32'd0);
        lat = 2;
        run_seq(3, 1'b0, 1'b0);

        for (int r = 0; r < 10; r++) begin
            repeat ($urandom_range(1, 3))
                tbl_wr($urandom_range(0, DEPTH - 1), 7'($urandom), 16'($urandom), 16'($urandom));
            lat     = $urandom_range(1, 4);
            cnt_v   = $urandom_range(0, 15);
            hang_en = ($urandom_range(0, 3) == 0);
            hang_rd = $urandom_range(0, DEPTH - 1);
            run_seq(cnt_v, 1'b0, 1'b0);
            hang_en = 1'b0;
        end

        repeat (4) @(negedge dclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
